// File: rtl/bno085_pkg.sv
// Shared constants and types for the BNO085 SPI responder.
package bno085_pkg;

    // SHTP header: len_lsb, len_msb, channel, sequence
    localparam int SHTP_HDR_LEN = 4;

    // SHTP channel numbers
    localparam logic [2:0] CH_CMD     = 3'd0;
    localparam logic [2:0] CH_EXEC    = 3'd1;
    localparam logic [2:0] CH_CTRL    = 3'd2;
    localparam logic [2:0] CH_REPORTS = 3'd3;
    localparam logic [2:0] CH_WAKE    = 3'd4;
    localparam logic [2:0] CH_GYRO    = 3'd5;

    // Framing FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_XFER  = 2'd3
    } resp_state_e;

    // Channels above the last defined one (6 and 7) are illegal
    function automatic logic chan_illegal(input logic [2:0] ch);
        return (ch > CH_GYRO);
    endfunction

endpackage

// File: rtl/bno085_spi_responder_phy.sv
// SPI mode-3 bit-level engine: synchronizers, edge detection, bit counters,
// tx/rx shift registers. Hands out one byte-done strobe per transmitted byte
// and samples the next tx byte from the framing logic at each byte boundary.
module spi_slave_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_n_i,
    input  logic       ps0_wake_i,
    input  logic [7:0] tx_byte_i,
    output logic       cs_fall_o,
    output logic       cs_rise_o,
    output logic       wake_fall_o,
    output logic       tx_byte_done_o,
    output logic       miso_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_first_o
);

    // Packed pin bundle order: {ps0_wake, cs_n, mosi, sclk}; idle levels
    localparam logic [3:0] SYNC_RST = 4'b1101;

    logic [3:0] sync_q [SYNC_STAGES];
    logic       sclk_s;
    logic       mosi_s;
    logic       cs_n_s;
    logic       wake_s;
    logic       sclk_prev_q;
    logic       cs_prev_q;
    logic       wake_prev_q;
    logic       sclk_fall_s;
    logic       sclk_rise_s;

    logic [2:0] tx_bit_q;
    logic [2:0] rx_bit_q;
    logic [7:0] tx_shift_q;
    logic [7:0] rx_shift_q;
    logic       first_pend_q;
    logic       miso_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       rx_first_q;
    logic       tx_done_q;

    // Multi-stage synchronizer for all asynchronous host pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
        end else begin
            sync_q[0] <= {ps0_wake_i, cs_n_i, mosi_i, sclk_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sclk_s = sync_q[SYNC_STAGES-1][0];
    assign mosi_s = sync_q[SYNC_STAGES-1][1];
    assign cs_n_s = sync_q[SYNC_STAGES-1][2];
    assign wake_s = sync_q[SYNC_STAGES-1][3];

    // Previous synchronized levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            wake_prev_q <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_n_s;
            wake_prev_q <= wake_s;
        end
    end

    // sclk edges only count while the chip is selected
    assign sclk_fall_s = sclk_prev_q & ~sclk_s & ~cs_n_s;
    assign sclk_rise_s = ~sclk_prev_q & sclk_s & ~cs_n_s;
    assign cs_fall_o   = cs_prev_q & ~cs_n_s;
    assign cs_rise_o   = ~cs_prev_q & cs_n_s;
    assign wake_fall_o = wake_prev_q & ~wake_s;

    // Bit counters, shift registers and the registered SPI/rx outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_bit_q     <= 3'd0;
            rx_bit_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            rx_shift_q   <= 8'h00;
            first_pend_q <= 1'b0;
            miso_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_first_q   <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_done_q  <= 1'b0;
            if (cs_fall_o) begin
                tx_bit_q     <= 3'd0;
                rx_bit_q     <= 3'd0;
                miso_q       <= 1'b0;
                first_pend_q <= 1'b1;
            end else if (cs_rise_o) begin
                // partial receive byte is dropped by clearing the counter
                tx_bit_q     <= 3'd0;
                rx_bit_q     <= 3'd0;
                miso_q       <= 1'b0;
                first_pend_q <= 1'b0;
            end else begin
                if (sclk_fall_s) begin
                    if (tx_bit_q == 3'd0) begin
                        miso_q     <= tx_byte_i[7];
                        tx_shift_q <= {tx_byte_i[6:0], 1'b0};
                    end else begin
                        miso_q     <= tx_shift_q[7];
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    end
                    tx_bit_q <= tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_done_q <= 1'b1;
                    end
                end
                if (sclk_rise_s) begin
                    rx_shift_q <= {rx_shift_q[6:0], mosi_s};
                    rx_bit_q   <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_valid_q   <= 1'b1;
                        rx_data_q    <= {rx_shift_q[6:0], mosi_s};
                        rx_first_q   <= first_pend_q;
                        first_pend_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign miso_o         = miso_q;
    assign rx_valid_o     = rx_valid_q;
    assign rx_data_o      = rx_data_q;
    assign rx_first_o     = rx_first_q;
    assign tx_byte_done_o = tx_done_q;

endmodule

// File: rtl/bno085_spi_responder.sv
// BNO085 sensor-hub SPI responder: buffers one payload, frames it with an
// SHTP header, raises int_n and streams it out over SPI mode 3.
module bno085_spi_responder
    import bno085_pkg::*;
#(
    parameter int PAYLOAD_MAX = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic       cs_n,
    input  logic       ps0_wake,
    output logic       int_n,
    input  logic       pkt_wr_valid,
    input  logic [7:0] pkt_wr_data,
    input  logic       pkt_wr_last,
    input  logic [2:0] pkt_channel,
    output logic       pkt_wr_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_first,
    output logic       tx_done,
    output logic       error
);

    localparam int CNT_W  = $clog2(PAYLOAD_MAX + 1);
    localparam int BUF_AW = $clog2(PAYLOAD_MAX);

    resp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       chan_q, chan_d;
    logic             discard_q, discard_d;
    logic             empty_q, empty_d;
    logic             int_n_q, int_n_d;
    logic             ready_q, ready_d;
    logic             tx_done_q, tx_done_d;
    logic             error_q, error_d;
    logic [15:0]      tx_idx_q, tx_idx_d;

    logic [7:0]       buf_q [PAYLOAD_MAX];
    logic [7:0]       seq_q [8];

    logic             accept_s;
    logic             force_last_s;
    logic             buf_we_s;
    logic             seq_inc_s;
    logic [BUF_AW-1:0] wr_idx_s;
    logic [BUF_AW-1:0] pay_idx_s;
    logic [15:0]      pkt_len_s;
    logic [7:0]       tx_byte_s;

    logic             cs_fall_s;
    logic             cs_rise_s;
    logic             wake_fall_s;
    logic             byte_done_s;

    spi_slave_phy #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_phy (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk_i         (sclk),
        .mosi_i         (mosi),
        .cs_n_i         (cs_n),
        .ps0_wake_i     (ps0_wake),
        .tx_byte_i      (tx_byte_s),
        .cs_fall_o      (cs_fall_s),
        .cs_rise_o      (cs_rise_s),
        .wake_fall_o    (wake_fall_s),
        .tx_byte_done_o (byte_done_s),
        .miso_o         (miso),
        .rx_valid_o     (rx_valid),
        .rx_data_o      (rx_data),
        .rx_first_o     (rx_first)
    );

    assign accept_s     = pkt_wr_valid & ready_q;
    // the byte that fills the buffer closes the packet even without last
    assign force_last_s = pkt_wr_last | (cnt_q == CNT_W'(PAYLOAD_MAX - 1));
    assign wr_idx_s     = BUF_AW'(cnt_q);
    assign pay_idx_s    = BUF_AW'(tx_idx_q - 16'd4);
    assign pkt_len_s    = 16'(cnt_q) + 16'(SHTP_HDR_LEN);

    // Select the outgoing byte for the current byte index of the transfer
    always_comb begin
        tx_byte_s = 8'h00;
        if ((state_q == ST_XFER) && !empty_q) begin
            case (tx_idx_q)
                16'd0:   tx_byte_s = pkt_len_s[7:0];
                16'd1:   tx_byte_s = pkt_len_s[15:8];
                16'd2:   tx_byte_s = {5'b00000, chan_q};
                16'd3:   tx_byte_s = seq_q[chan_q];
                default: begin
                    if (tx_idx_q < pkt_len_s) begin
                        tx_byte_s = buf_q[pay_idx_s];
                    end else begin
                        tx_byte_s = 8'h00;
                    end
                end
            endcase
        end else begin
            tx_byte_s = 8'h00;
        end
    end

    // Framing FSM: next-state and control decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        discard_d = discard_q;
        empty_d   = empty_q;
        int_n_d   = int_n_q;
        tx_idx_d  = tx_idx_q;
        tx_done_d = 1'b0;
        error_d   = 1'b0;
        buf_we_s  = 1'b0;
        seq_inc_s = 1'b0;

        if (cs_fall_s) begin
            tx_idx_d = 16'd0;
        end else if (byte_done_s && (tx_idx_q != 16'hFFFF)) begin
            tx_idx_d = tx_idx_q + 16'd1;
        end else begin
            tx_idx_d = tx_idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (discard_q) begin
                        discard_d = ~pkt_wr_last;
                    end else if (chan_illegal(pkt_channel)) begin
                        error_d   = 1'b1;
                        discard_d = ~pkt_wr_last;
                    end else begin
                        buf_we_s = 1'b1;
                        cnt_d    = CNT_W'(1);
                        chan_d   = pkt_channel;
                        empty_d  = 1'b0;
                        if (force_last_s) begin
                            state_d = ST_READY;
                            int_n_d = 1'b0;
                        end else begin
                            state_d = ST_LOAD;
                            int_n_d = 1'b1;
                        end
                    end
                end else if (cs_fall_s) begin
                    // host write or wake-initiated read: empty packet
                    state_d = ST_XFER;
                    empty_d = 1'b1;
                    int_n_d = 1'b1;
                end else if (wake_fall_s) begin
                    empty_d = 1'b1;
                    int_n_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    buf_we_s = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (force_last_s) begin
                        state_d = ST_READY;
                        int_n_d = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_READY: begin
                if (cs_fall_s) begin
                    state_d = ST_XFER;
                    int_n_d = 1'b1;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_XFER: begin
                if (cs_rise_s) begin
                    if (empty_q) begin
                        empty_d = 1'b0;
                        int_n_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tx_idx_q >= pkt_len_s) begin
                        tx_done_d = 1'b1;
                        seq_inc_s = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        // aborted read: keep the packet and re-arm int_n
                        state_d = ST_READY;
                        int_n_d = 1'b0;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    // Framing FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            chan_q    <= 3'd0;
            discard_q <= 1'b0;
            empty_q   <= 1'b0;
            int_n_q   <= 1'b1;
            ready_q   <= 1'b1;
            tx_done_q <= 1'b0;
            error_q   <= 1'b0;
            tx_idx_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chan_q    <= chan_d;
            discard_q <= discard_d;
            empty_q   <= empty_d;
            int_n_q   <= int_n_d;
            ready_q   <= ready_d;
            tx_done_q <= tx_done_d;
            error_q   <= error_d;
            tx_idx_q  <= tx_idx_d;
        end
    end

    // Payload buffer write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAYLOAD_MAX; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else if (buf_we_s) begin
            buf_q[wr_idx_s] <= pkt_wr_data;
        end
    end

    // Per-channel SHTP sequence numbers, bumped on each completed delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                seq_q[i] <= 8'h00;
            end
        end else if (seq_inc_s) begin
            seq_q[chan_q] <= seq_q[chan_q] + 8'd1;
        end
    end

    assign int_n        = int_n_q;
    assign pkt_wr_ready = ready_q;
    assign tx_done      = tx_done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_bno085_spi_responder.sv
// Self-checking bench: scoreboard queues filled from a packet-level model,
// drained by monitors watching rx_valid, tx_done/error and the miso stream.
module tb_bno085_spi_responder;

    localparam int PMAX = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;
    logic       ps0_wake;
    logic       int_n;
    logic       pkt_wr_valid;
    logic [7:0] pkt_wr_data;
    logic       pkt_wr_last;
    logic [2:0] pkt_channel;
    logic       pkt_wr_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       tx_done;
    logic       error;

    bno085_spi_responder #(
        .PAYLOAD_MAX(PMAX),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .cs_n         (cs_n),
        .ps0_wake     (ps0_wake),
        .int_n        (int_n),
        .pkt_wr_valid (pkt_wr_valid),
        .pkt_wr_data  (pkt_wr_data),
        .pkt_wr_last  (pkt_wr_last),
        .pkt_channel  (pkt_channel),
        .pkt_wr_ready (pkt_wr_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_first     (rx_first),
        .tx_done      (tx_done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_pass    = 0;
    int pulse_cnt = 0;

    // scoreboard queues
    logic [7:0] exp_miso_q [$];
    logic [8:0] exp_rx_q [$];
    int         exp_evt_q [$];   // 1 = tx_done, 2 = error

    // packet-level reference model
    int         seq_m [8];
    bit         pend_m;
    int         ch_m;
    logic [7:0] pay_m [$];

    logic [7:0] host_tx_q [$];
    logic [7:0] ld_q [$];

    logic [8:0] rx_exp_v;
    int         evt_exp_v;
    int         evt_act_v;
    logic [7:0] mshift = 8'h00;
    int         mbits  = 0;
    logic [7:0] miso_exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // monitor: received bytes and event pulses
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid) begin
                pulse_cnt++;
                if (exp_rx_q.size() == 0) begin
                    check("rx_unexpected", exp_rx_q.size(), 1);
                end else begin
                    rx_exp_v = exp_rx_q.pop_front();
                    check("rx_byte", {rx_first, rx_data}, rx_exp_v);
                end
            end
            if (tx_done || error) begin
                pulse_cnt++;
                evt_act_v = {30'd0, error, tx_done};
                if (exp_evt_q.size() == 0) begin
                    check("evt_unexpected", evt_act_v, 0);
                end else begin
                    evt_exp_v = exp_evt_q.pop_front();
                    check("evt", evt_act_v, evt_exp_v);
                end
            end
        end
    end

    // monitor: host-side view of miso, sampled on sclk rise (mode 3)
    always @(posedge sclk) begin
        if (cs_n === 1'b0) begin
            mshift = {mshift[6:0], miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_miso_q.size() == 0) begin
                    check("miso_unexpected", exp_miso_q.size(), 1);
                end else begin
                    miso_exp_v = exp_miso_q.pop_front();
                    check("miso_byte", mshift, miso_exp_v);
                end
            end
        end
    end

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: run exceeded %0d cycles", 120000);
        $fatal(1, "watchdog");
    end

    task automatic spi_xfer(input int n);
        logic [7:0] b;
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            b = host_tx_q[i];
            for (int k = 7; k >= 0; k--) begin
                sclk = 1'b0;
                mosi = b[k];
                repeat (5) @(negedge clk);
                sclk = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // host reads n bytes; model decides what the responder must send
    task automatic do_read(input int n, input bit rnd);
        logic [7:0] stream [$];
        int plen;
        stream = {};
        plen = 0;
        if (pend_m) begin
            plen = pay_m.size() + 4;
            stream.push_back(8'(plen));
            stream.push_back(8'(plen >> 8));
            stream.push_back(8'(ch_m));
            stream.push_back(8'(seq_m[ch_m]));
            foreach (pay_m[i]) stream.push_back(pay_m[i]);
        end
        if (rnd) begin
            host_tx_q = {};
            for (int i = 0; i < n; i++) host_tx_q.push_back(8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < n; i++) begin
            exp_miso_q.push_back((i < stream.size()) ? stream[i] : 8'h00);
            exp_rx_q.push_back({(i == 0), host_tx_q[i]});
        end
        if (pend_m && (n >= plen)) begin
            exp_evt_q.push_back(1);
            seq_m[ch_m] = (seq_m[ch_m] + 1) % 256;
            pend_m = 1'b0;
        end
        spi_xfer(n);
    endtask

    // writes ld_q[0..n-1]; acc = bytes the DUT actually accepted
    task automatic load_pkt(input int ch, input int n, input bit with_last, output int acc);
        int w;
        acc = 0;
        if (ch >= 6) begin
            exp_evt_q.push_back(2);
        end else begin
            pend_m = 1'b1;
            ch_m   = ch;
            pay_m  = {};
            for (int i = 0; i < n && i < PMAX; i++) pay_m.push_back(ld_q[i]);
        end
        for (int i = 0; i < n; i++) begin
            w = 0;
            while ((pkt_wr_ready !== 1'b1) && (w < 4)) begin
                @(negedge clk);
                w++;
            end
            if (pkt_wr_ready !== 1'b1) break;
            pkt_wr_valid = 1'b1;
            pkt_wr_data  = ld_q[i];
            pkt_wr_last  = with_last && (i == n - 1);
            pkt_channel  = 3'(ch);
            @(negedge clk);
            pkt_wr_valid = 1'b0;
            pkt_wr_last  = 1'b0;
            acc++;
        end
    endtask

    int acc;
    int p0;
    int len_r;
    int ch_r;

    initial begin
        rst_n        = 1'b0;
        sclk         = 1'b1;
        mosi         = 1'b0;
        cs_n         = 1'b1;
        ps0_wake     = 1'b1;
        pkt_wr_valid = 1'b0;
        pkt_wr_data  = 8'h00;
        pkt_wr_last  = 1'b0;
        pkt_channel  = 3'd0;
        pend_m       = 1'b0;
        ch_m         = 0;
        for (int i = 0; i < 8; i++) seq_m[i] = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset values and quiet idle
        check("rst_int_n", int_n, 1);
        check("rst_miso", miso, 0);
        check("rst_ready", pkt_wr_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_first", rx_first, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_error", error, 0);
        p0 = pulse_cnt;
        repeat (100) @(negedge clk);
        check("idle_no_pulses", pulse_cnt - p0, 0);
        check("idle_int_n", int_n, 1);

        // 2: AA BB CC on ch3, full read twice
        ld_q = '{8'hAA, 8'hBB, 8'hCC};
        load_pkt(3, 3, 1'b1, acc);
        check("t2_acc", acc, 3);
        check("t2_int_low", int_n, 0);
        check("t2_ready_low", pkt_wr_ready, 0);
        do_read(8, 1'b1);
        check("t2_int_high", int_n, 1);
        load_pkt(3, 3, 1'b1, acc);
        do_read(8, 1'b1);
        check("t2b_int_high", int_n, 1);

        // 3: host write with nothing loaded
        host_tx_q = '{8'h05, 8'h00, 8'h02, 8'h00, 8'hF9};
        do_read(5, 1'b0);
        check("t3_int_high", int_n, 1);
        check("t3_ready", pkt_wr_ready, 1);

        // 4: aborted read keeps the packet
        ld_q = '{8'h11, 8'h22, 8'h33};
        load_pkt(5, 3, 1'b1, acc);
        do_read(5, 1'b1);
        check("t4_int_rearm", int_n, 0);
        check("t4_ready_low", pkt_wr_ready, 0);
        do_read(7, 1'b1);
        check("t4_int_high", int_n, 1);

        // 5: wake request produces an empty packet
        ps0_wake = 1'b0;
        repeat (4) @(negedge clk);
        ps0_wake = 1'b1;
        repeat (8) @(negedge clk);
        check("t5_int_low", int_n, 0);
        do_read(4, 1'b1);
        check("t5_int_high", int_n, 1);
        check("t5_idle_ready", pkt_wr_ready, 1);

        // 6: illegal channel, then buffer overflow
        ld_q = '{8'h01, 8'h02, 8'h03};
        load_pkt(6, 3, 1'b1, acc);
        repeat (4) @(negedge clk);
        check("t6_int_high", int_n, 1);
        check("t6_ready", pkt_wr_ready, 1);
        ld_q = {};
        for (int i = 0; i < PMAX + 1; i++) ld_q.push_back(8'($urandom_range(0, 255)));
        load_pkt(2, PMAX + 1, 1'b0, acc);
        check("t6_acc_full", acc, PMAX);
        check("t6_ready_low", pkt_wr_ready, 0);
        check("t6_int_low", int_n, 0);
        do_read(PMAX + 5, 1'b1);

        // randomized packets, optionally with an aborted first read
        for (int it = 0; it < 6; it++) begin
            len_r = $urandom_range(1, 16);
            ch_r  = $urandom_range(0, 5);
            ld_q  = {};
            for (int i = 0; i < len_r; i++) ld_q.push_back(8'($urandom_range(0, 255)));
            load_pkt(ch_r, len_r, 1'b1, acc);
            check("rnd_acc", acc, len_r);
            check("rnd_int_low", int_n, 0);
            if ($urandom_range(0, 1) == 1) begin
                do_read($urandom_range(1, len_r + 3), 1'b1);
                check("rnd_abort_int", int_n, 0);
            end
            do_read(len_r + 4 + $urandom_range(0, 2), 1'b1);
            check("rnd_int_high", int_n, 1);
        end

        repeat (20) @(negedge clk);
        check("miso_q_drained", exp_miso_q.size(), 0);
        check("rx_q_drained", exp_rx_q.size(), 0);
        check("evt_q_drained", exp_evt_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
